// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared limits, set-state encoding and wrap helpers for the time-of-day block
package rtc_pkg;

  localparam logic [5:0] MAX_HOUR = 6'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } set_state_e;

  function automatic int div_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  // >= keeps out-of-range values from running away: they fold back to 0
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec_wrap(input logic [5:0] v, input logic [5:0] max);
    return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// rtl/rtc_timekeeper_if.sv - button, preset and time/display signal bundle for rtc_timekeeper
interface rtc_timekeeper_if;
  logic       mode_p;
  logic       up_p;
  logic       down_p;
  logic       hold;
  logic       fmt_12h;
  logic       load;
  logic [5:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [5:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [5:0] disp_hour;
  logic       pm;
  logic [1:0] set_state;
  logic       blink;
  logic       day_tick;
  logic       load_err;

  modport master (
    output mode_p, up_p, down_p, hold, fmt_12h, load, load_hour, load_min, load_sec,
    input  hour, min, sec, disp_hour, pm, set_state, blink, day_tick, load_err
  );

  modport slave (
    input  mode_p, up_p, down_p, hold, fmt_12h, load, load_hour, load_min, load_sec,
    output hour, min, sec, disp_hour, pm, set_state, blink, day_tick, load_err
  );
endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-DIV tick generator with run enable and synchronous clear
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int W = rtc_pkg::div_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt >= LAST) ? '0 : cnt + 1'b1;
    end
  end

  // clear wins over a terminal count so a cleared cycle never advances time
  assign tick = run && !clear && (cnt >= LAST);

endmodule

// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - 24h time-of-day counter with set-mode FSM, preset load, hold and 12h display
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int TICK_HZ      = 1,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic         clk,
  input  logic         rst,
  rtc_timekeeper_if.slave bus
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int BW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  set_state_e    state, next_state;
  logic [5:0]    hour_q, min_q, sec_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_q, day_tick_q, load_err_q;
  logic          load_ok, edit, run, clear, tick;

  assign load_ok = (bus.load_hour <= MAX_HOUR) && (bus.load_min <= MAX_MIN) &&
                   (bus.load_sec <= MAX_SEC);
  assign edit    = bus.up_p ^ bus.down_p;
  assign run     = (state == RUN) && !bus.hold;
  assign clear   = bus.load || bus.mode_p || (state != RUN);

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .clear (clear),
    .tick  (tick)
  );

  always_comb begin
    next_state = state;
    if (bus.load) begin
      if (load_ok) next_state = RUN;
    end else if (bus.mode_p) begin
      case (state)
        RUN:      next_state = SET_HOUR;
        SET_HOUR: next_state = SET_MIN;
        default:  next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      blink_cnt  <= '0;
      blink_q    <= 1'b1;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state      <= next_state;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;

      // a load pulse owns the cycle even when rejected
      if (bus.load) begin
        if (load_ok) begin
          hour_q <= bus.load_hour;
          min_q  <= bus.load_min;
          sec_q  <= bus.load_sec;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (bus.mode_p) begin
        if (state == SET_MIN) sec_q <= '0;
      end else if (state == SET_HOUR && edit) begin
        hour_q <= bus.up_p ? inc_wrap(hour_q, MAX_HOUR) : dec_wrap(hour_q, MAX_HOUR);
      end else if (state == SET_MIN && edit) begin
        min_q <= bus.up_p ? inc_wrap(min_q, MAX_MIN) : dec_wrap(min_q, MAX_MIN);
      end else if (tick) begin
        sec_q <= inc_wrap(sec_q, MAX_SEC);
        if (sec_q >= MAX_SEC) begin
          min_q <= inc_wrap(min_q, MAX_MIN);
          if (min_q >= MAX_MIN) begin
            hour_q <= inc_wrap(hour_q, MAX_HOUR);
            if (hour_q >= MAX_HOUR) day_tick_q <= 1'b1;
          end
        end
      end

      // every entry into an edit state restarts the blink phase visible
      if (next_state == RUN || next_state != state) begin
        blink_cnt <= '0;
        blink_q   <= 1'b1;
      end else if (blink_cnt >= BLINK_LAST) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.disp_hour = hour_q;
    if (bus.fmt_12h) begin
      if (hour_q == 6'd0)       bus.disp_hour = 6'd12;
      else if (hour_q > 6'd12)  bus.disp_hour = hour_q - 6'd12;
    end
  end

  assign bus.pm        = (hour_q >= 6'd12);
  assign bus.hour      = hour_q;
  assign bus.min       = min_q;
  assign bus.sec       = sec_q;
  assign bus.set_state = state;
  assign bus.blink     = blink_q;
  assign bus.day_tick  = day_tick_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
- Parametrised successor to the board's basic time-of-day counter.
- Adds the following:
  - on-chip 1 Hz tick prescaler;
  - explicit set-mode state machine (hour/minute, with up and down);
  - 12/24-hour display conversion;
  - synchronous preset load;
  - hold/freeze;
  - midnight carry pulse for a future date counter.
- Sits between the debounced, edge-detected button pulses and the 7-segment display formatter.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1, timekeeping tick rate. DIV = CLK_FREQ_HZ/TICK_HZ, must be >= 2.
- BLINK_CYCLES, 25_000_000, clk cycles per blink half-period in set states. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mode_p  in  1  single-cycle pulse: advance set-mode FSM.
- up_p  in  1  single-cycle pulse: increment selected field.
- down_p  in  1  single-cycle pulse: decrement selected field.
- hold  in  1  level: freeze timekeeping in RUN.
- fmt_12h  in  1  level: 1 = 12-hour display format.
- load  in  1  single-cycle pulse: preset time.
- load_hour  in  6  preset hour, 0-23.
- load_min  in  6  preset minute, 0-59.
- load_sec  in  6  preset second, 0-59.
- hour  out  6  internal 24-hour value.
- min  out  6  minutes.
- sec  out  6  seconds.
- disp_hour  out  6  display hour (12h or 24h).
- pm  out  1  1 when hour >= 12, in both formats.
- set_state  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN.
- blink  out  1  display-enable for the field being edited.
- day_tick  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - hour = min = sec = 0; set_state = RUN.
  - prescaler = 0, blink counter = 0.
  - blink = 1, day_tick = 0, load_err = 0.
- Prescaler:
  - Counts 0..DIV-1. Internal tick fires on the cycle it holds DIV-1, then wraps to 0.
  - Counts only in RUN with hold = 0. Frozen while hold = 1.
  - Forced to 0 in SET states, on load, and on any FSM transition.
- RUN tick (all updates registered on the same clk edge):
  - sec increments.
  - At sec = 59: sec -> 0 and min increments.
  - At min = 59: min -> 0 and hour increments.
  - At hour = 23: hour -> 0 and day_tick = 1 on the next cycle only.
- FSM on mode_p:
  - RUN -> SET_HOUR -> SET_MIN -> RUN.
  - On SET_MIN -> RUN: sec is cleared to 0.
- Set edits:
  - SET_HOUR: up_p gives 23 -> 0 wrap; down_p gives 0 -> 23.
  - SET_MIN: up_p gives 59 -> 0 wrap; down_p gives 0 -> 59.
  - No carry or borrow between fields in set mode.
  - up_p and down_p are ignored in RUN.
- Priority, per cycle: rst > load > mode_p > up_p/down_p > tick.
  - up_p and down_p asserted together: no change.
  - mode_p together with up_p or down_p: only the FSM advances.
- Load:
  - Accepted when load_hour <= 23, load_min <= 59 and load_sec <= 59.
  - On accept: all three fields are written, set_state -> RUN, prescaler -> 0.
  - Otherwise all fields are unchanged and load_err pulses for one cycle.
  - Load is valid in any state.
- Blink:
  - 1 in RUN.
  - In SET states it toggles every BLINK_CYCLES clk cycles, starting at 1 on state entry.
- Display conversion (combinational from registers, zero latency):
  - fmt_12h = 0: disp_hour = hour.
  - fmt_12h = 1: hour 0 -> 12, 1..12 -> unchanged, 13..23 -> hour-12.
- Width: all counters are unsigned. Comparisons use >= limit so that corrupted values recover on the next increment.

Decomposition:
- Package rtc_pkg: MAX_HOUR = 23, MAX_MIN = 59, MAX_SEC = 59, set_state encodings RUN/SET_HOUR/SET_MIN, and a DIV-width helper constant (clog2 of DIV).
- Sub-module tick_prescaler, with parameter DIV.
  - Inputs: clk, rst, run, clear.
  - Output: tick.
  - Reused later by the stopwatch block.

Test Plan (CLK_FREQ_HZ = 10, TICK_HZ = 1, BLINK_CYCLES = 4):
1. Reset, then 600 clk in RUN -> sec = 0, min = 1, hour = 0. First tick lands on clk 10 after reset release.
2. Load 23:59:58, then wait 20 clk -> reads 00:00:00. day_tick is high for exactly 1 cycle; no other day_tick.
3. mode_p, then 2x down_p -> SET_HOUR, hour 0 -> 23 -> 22. mode_p, then up_p at min = 59 -> min = 0, hour stays 22. mode_p -> RUN with sec = 0. blink toggles every 4 clk while in SET.
4. Load 12:00:00 with fmt_12h = 1 -> disp_hour = 12, pm = 1. Load 00:30:00 -> disp_hour = 12, pm = 0. Load 13:00:00 -> disp_hour = 1, pm = 1.
5. Load 24:00:00 -> load_err pulses once, time unchanged. Load with mode_p in the same cycle -> load wins, state RUN.
6. hold = 1 for 50 clk at 00:00:05 -> time still 00:00:05. Release -> next tick after the remaining prescaler count. up_p and down_p together in SET_MIN -> min unchanged. rst asserted mid-SET_MIN -> all values return to reset values.
